// File: rtl/regfile_seq_pkg.sv
// Shared types and default sizes for the register-file access sequencer.
//   seq_state_t : top-level sequencer state (INIT sweep, then RUN)
//   rsp_entry_t : one read response (source address + data) at default widths
package regfile_seq_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 4;
  localparam int DEF_RESP_DEPTH = 4;

  typedef enum logic [0:0] {
    SEQ_INIT = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/regfile_resp_fifo.sv
// Synchronous response FIFO holding read responses in issue order.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (clears storage too,
//                  so the head reads as zero after reset)
//   push, push_data : write one entry at the tail
//   pop          : remove the head entry (ignored when empty)
//   head         : current head entry
//   count        : number of stored entries
//   empty        : no entries stored
module regfile_resp_fifo
  import regfile_seq_pkg::*;
#(
  parameter int  DEPTH   = DEF_RESP_DEPTH,
  parameter type entry_t = rsp_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             empty_r;
  logic             full_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with explicit wrap so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Qualified push/pop and next occupancy; a push into a full FIFO is only
  // taken when the head leaves in the same cycle.
  always_comb begin
    do_pop_s     = pop && !empty_r;
    do_push_s    = push && (!full_r || do_pop_s);
    count_next_s = count_r;
    if (do_push_s && !do_pop_s) begin
      count_next_s = count_r + CNT_W'(1);
    end else if (!do_push_s && do_pop_s) begin
      count_next_s = count_r - CNT_W'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // Storage, pointers and occupancy flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      empty_r  <= 1'b1;
      full_r   <= 1'b0;
    end else begin
      if (do_push_s) begin
        mem[wr_ptr_r] <= push_data;
        wr_ptr_r      <= ptr_inc(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_next_s;
      empty_r <= (count_next_s == {CNT_W{1'b0}});
      full_r  <= (count_next_s == CNT_W'(DEPTH));
    end
  end

  assign head  = mem[rd_ptr_r];
  assign count = count_r;
  assign empty = empty_r;

endmodule

// File: rtl/regfile_access_sequencer.sv
// Initiator for a pipelined register file with a one-cycle registered read.
// After reset an optional sweep writes INIT_VALUE to every register, then
// read/write requests are accepted over a valid/ready port and read data is
// returned in order over a valid/ready response port.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   req_*             : request port (valid/ready, write flag, address, data)
//   rsp_*             : response port (valid/ready, read data, source address)
//   init_done         : sticky until reset once the sweep has completed
//   rf_*              : registered pins to/from the register file
module regfile_access_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int                 DATA_W     = DEF_DATA_W,
  parameter int                 ADDR_W     = DEF_ADDR_W,
  parameter int                 RESP_DEPTH = DEF_RESP_DEPTH,
  parameter bit                 INIT_EN    = 1'b1,
  parameter logic [DATA_W-1:0]  INIT_VALUE = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              init_done,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [ADDR_W-1:0] rf_read_address,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int CNT_W    = $clog2(RESP_DEPTH + 1);
  localparam int CRD_W    = CNT_W + 2;
  localparam seq_state_t RESET_STATE = INIT_EN ? SEQ_INIT : SEQ_RUN;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  seq_state_t        state_r;
  seq_state_t        state_next_s;
  logic [ADDR_W-1:0] init_addr_r;
  logic              init_done_r;
  logic              ready_r;

  logic              accept_wr_s;
  logic              accept_rd_s;
  logic              rsp_pop_s;

  // Read pipeline: s1 = address on rf_read_address, s2 = data on rf_data_out.
  logic              s1_valid_r;
  logic              s2_valid_r;
  logic [ADDR_W-1:0] s2_addr_r;

  logic              rf_we_r;
  logic [ADDR_W-1:0] rf_waddr_r;
  logic [ADDR_W-1:0] rf_raddr_r;
  logic [DATA_W-1:0] rf_din_r;

  entry_t            push_entry_s;
  entry_t            fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_empty_s;
  logic [CRD_W-1:0]  count_next_s;
  logic [CRD_W-1:0]  used_next_s;

  assign accept_wr_s = req_valid && ready_r && req_write;
  assign accept_rd_s = req_valid && ready_r && !req_write;
  assign rsp_pop_s   = !fifo_empty_s && rsp_ready;

  // Sweep ends after the write to the last address; RUN is terminal.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SEQ_INIT: begin
        if (init_addr_r == ADDR_W'(NUM_REGS - 1)) begin
          state_next_s = SEQ_RUN;
        end else begin
          state_next_s = SEQ_INIT;
        end
      end
      SEQ_RUN:  state_next_s = SEQ_RUN;
      default:  state_next_s = RESET_STATE;
    endcase
  end

  // Credits in use next cycle: FIFO entries plus reads still in s1/s2.
  // req_ready is registered, so it is computed from next-cycle occupancy;
  // this equals the RUN && (count + s1 + s2 < RESP_DEPTH) rule each cycle.
  always_comb begin
    count_next_s = CRD_W'(fifo_count_s);
    if (s2_valid_r && !rsp_pop_s) begin
      count_next_s = CRD_W'(fifo_count_s) + CRD_W'(1);
    end else if (!s2_valid_r && rsp_pop_s) begin
      count_next_s = CRD_W'(fifo_count_s) - CRD_W'(1);
    end else begin
      count_next_s = CRD_W'(fifo_count_s);
    end
    used_next_s = count_next_s + CRD_W'(accept_rd_s) + CRD_W'(s1_valid_r);
  end

  // Sequencer state, sweep counter and status flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= RESET_STATE;
      init_addr_r <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
      ready_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      init_done_r <= (state_next_s == SEQ_RUN);
      ready_r     <= (state_next_s == SEQ_RUN) && (used_next_s < CRD_W'(RESP_DEPTH));
      if (state_r == SEQ_INIT) begin
        init_addr_r <= init_addr_r + ADDR_W'(1);
      end
    end
  end

  // Register-file pins: sweep writes, accepted writes, accepted read address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {ADDR_W{1'b0}};
      rf_din_r   <= {DATA_W{1'b0}};
      rf_raddr_r <= {ADDR_W{1'b0}};
    end else begin
      if (state_r == SEQ_INIT) begin
        rf_we_r    <= 1'b1;
        rf_waddr_r <= init_addr_r;
        rf_din_r   <= INIT_VALUE;
      end else if (accept_wr_s) begin
        rf_we_r    <= 1'b1;
        rf_waddr_r <= req_addr;
        rf_din_r   <= req_wdata;
      end else begin
        rf_we_r    <= 1'b0;
      end
      if (accept_rd_s) begin
        rf_raddr_r <= req_addr;
      end
    end
  end

  // Read tracking: s2 captures rf_data_out only when it holds a read.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s2_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      s1_valid_r <= accept_rd_s;
      s2_valid_r <= s1_valid_r;
      s2_addr_r  <= rf_raddr_r;
    end
  end

  assign push_entry_s = '{addr: s2_addr_r, data: rf_data_out};

  regfile_resp_fifo #(
    .DEPTH   (RESP_DEPTH),
    .entry_t (entry_t)
  ) u_resp_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (s2_valid_r),
    .push_data (push_entry_s),
    .pop       (rsp_pop_s),
    .head      (fifo_head_s),
    .count     (fifo_count_s),
    .empty     (fifo_empty_s)
  );

  assign req_ready        = ready_r;
  assign init_done        = init_done_r;
  assign rsp_valid        = !fifo_empty_s;
  assign rsp_rdata        = fifo_head_s.data;
  assign rsp_addr         = fifo_head_s.addr;
  assign rf_write_enable  = rf_we_r;
  assign rf_write_address = rf_waddr_r;
  assign rf_read_address  = rf_raddr_r;
  assign rf_data_in       = rf_din_r;

endmodule
